// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the IF and MEM stages, the arbiter and the byte-wide RAM.
// The slave modport is the arbiter's view; the master modport is the requesters plus RAM.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_done;
   logic [31:0]       if_data;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wr;
   logic [1:0]        mem_len;
   logic [31:0]       mem_wdata;
   logic              mem_done;
   logic [31:0]       mem_rdata;

   logic [7:0]        ram_din;
   logic [7:0]        ram_dout;
   logic [ADDR_W-1:0] ram_a;
   logic              ram_wr;

   modport slave (
      input  if_req, if_addr, if_flush,
      input  mem_req, mem_addr, mem_wr, mem_len, mem_wdata,
      input  ram_din,
      output if_done, if_data, mem_done, mem_rdata,
      output ram_dout, ram_a, ram_wr
   );

   modport master (
      output if_req, if_addr, if_flush,
      output mem_req, mem_addr, mem_wr, mem_len, mem_wdata,
      output ram_din,
      input  if_done, if_data, mem_done, mem_rdata,
      input  ram_dout, ram_a, ram_wr
   );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serialising arbiter for the single RAM port: MEM loads/stores take priority over IF
// fetches; each access is split into byte cycles and reassembled little-endian.
module mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rdy,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   logic              owner_mem;
   logic              wr_q;
   logic [2:0]        n_q;
   logic [2:0]        cnt;
   logic [ADDR_W-1:0] base_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rbuf;
   logic              fresh;

   logic              if_done_q;
   logic              mem_done_q;
   logic [31:0]       if_data_q;
   logic [31:0]       mem_rdata_q;
   logic [ADDR_W-1:0] ram_a_q;
   logic [7:0]        ram_dout_q;
   logic              ram_wr_q;

   logic [31:0]       next_buf;
   logic [1:0]        cap_idx;
   logic [2:0]        nxt;
   logic              last;

   function automatic logic [2:0] len_to_n(input logic [1:0] len);
      case (len)
         2'd1:    return 3'd1;
         2'd2:    return 3'd2;
         2'd3:    return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
      return w[{idx, 3'b000} +: 8];
   endfunction

   // fresh marks the first cycle after cnt moved, the only cycle in which ram_din carries
   // byte cnt-1; a stall re-reads the RAM, so that byte is captured even while rdy is low.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch can be inferred.
      next_buf = rbuf;
      cap_idx  = cnt[1:0] - 2'd1;
      if (fresh && !wr_q && cnt != 3'd0)
         next_buf[{cap_idx, 3'b000} +: 8] = bus.ram_din;
      nxt  = cnt + 3'd1;
      last = wr_q ? (cnt == n_q - 3'd1) : (cnt == n_q);
   end

   // NOTE: all state and registered outputs use non-blocking assignments in this one block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         owner_mem   <= 1'b0;
         wr_q        <= 1'b0;
         n_q         <= '0;
         cnt         <= '0;
         base_q      <= '0;
         wdata_q     <= '0;
         rbuf        <= '0;
         fresh       <= 1'b0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
         ram_a_q     <= '0;
         ram_dout_q  <= '0;
         ram_wr_q    <= 1'b0;
      end else if (!rdy) begin
         if (state == BUSY) begin
            rbuf  <= next_buf;
            fresh <= 1'b0;
         end
      end else begin
         case (state)
            IDLE: begin
               rbuf <= '0;
               cnt  <= '0;
               if (bus.mem_req && bus.mem_len != 2'd0) begin
                  state      <= BUSY;
                  owner_mem  <= 1'b1;
                  base_q     <= bus.mem_addr;
                  n_q        <= len_to_n(bus.mem_len);
                  wr_q       <= bus.mem_wr;
                  wdata_q    <= bus.mem_wdata;
                  fresh      <= 1'b1;
                  ram_a_q    <= bus.mem_addr;
                  ram_wr_q   <= bus.mem_wr;
                  ram_dout_q <= bus.mem_wdata[7:0];
               end else if (bus.if_req && !bus.if_flush) begin
                  state      <= BUSY;
                  owner_mem  <= 1'b0;
                  base_q     <= bus.if_addr;
                  n_q        <= 3'd4;
                  wr_q       <= 1'b0;
                  wdata_q    <= '0;
                  fresh      <= 1'b1;
                  ram_a_q    <= bus.if_addr;
                  ram_wr_q   <= 1'b0;
                  ram_dout_q <= '0;
               end
            end
            BUSY: begin
               if (!owner_mem && bus.if_flush) begin
                  state      <= IDLE;
                  fresh      <= 1'b0;
                  ram_a_q    <= '0;
                  ram_wr_q   <= 1'b0;
                  ram_dout_q <= '0;
               end else if (last) begin
                  state      <= DONE;
                  fresh      <= 1'b0;
                  ram_a_q    <= '0;
                  ram_wr_q   <= 1'b0;
                  ram_dout_q <= '0;
                  if (owner_mem) begin
                     mem_done_q <= 1'b1;
                     if (!wr_q) mem_rdata_q <= next_buf;
                  end else begin
                     if_done_q <= 1'b1;
                     if_data_q <= next_buf;
                  end
               end else begin
                  cnt   <= nxt;
                  rbuf  <= next_buf;
                  fresh <= 1'b1;
                  if (nxt < n_q) begin
                     ram_a_q    <= base_q + ADDR_W'(nxt);
                     ram_wr_q   <= wr_q;
                     ram_dout_q <= byte_sel(wdata_q, nxt[1:0]);
                  end else begin
                     ram_a_q    <= '0;
                     ram_wr_q   <= 1'b0;
                     ram_dout_q <= '0;
                  end
               end
            end
            DONE: begin
               if_done_q  <= 1'b0;
               mem_done_q <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.if_done   = if_done_q;
   assign bus.if_data   = if_data_q;
   assign bus.mem_done  = mem_done_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign bus.ram_a     = ram_a_q;
   assign bus.ram_dout  = ram_dout_q;
   // A stalled store byte must not be written while rdy is low, so the strobe is gated here.
   assign bus.ram_wr    = ram_wr_q & rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed IF/MEM transactions against a 4 KiB byte RAM model, with
// expected results queued per requester and compared by a done-pulse monitor.
module tb_mem_arbiter;

   typedef struct {
      logic [31:0] data;
      logic        chk;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
      int          cyc;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   logic rdy;

   mem_arbiter_if #(.ADDR_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;
   exp_t if_q[$];
   exp_t mem_q[$];
   wr_t  wlog[$];

   logic [7:0]  ram [0:4095];
   logic        bd_we = 1'b0;
   logic [11:0] bd_addr = '0;
   logic [7:0]  bd_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read byte RAM: data for ram_a appears on ram_din the following cycle.
   always @(posedge clk) begin
      bus.ram_din <= ram[bus.ram_a[11:0]];
      if (bus.ram_wr) begin
         ram[bus.ram_a[11:0]] <= bus.ram_dout;
         wlog.push_back('{bus.ram_a, bus.ram_dout, cyc});
      end else if (bd_we) begin
         ram[bd_addr] <= bd_data;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   exp_t ei, em;
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.if_done) begin
            if (if_q.size() == 0) check("if_done unexpected", 32'd1, 32'd0);
            else begin
               ei = if_q.pop_front();
               check("if_data", bus.if_data, ei.data);
               check("if_done cycle", cyc, ei.cyc);
            end
         end
         if (bus.mem_done) begin
            if (mem_q.size() == 0) check("mem_done unexpected", 32'd1, 32'd0);
            else begin
               em = mem_q.pop_front();
               if (em.chk) check("mem_rdata", bus.mem_rdata, em.data);
               check("mem_done cycle", cyc, em.cyc);
            end
         end
      end
   end

   task automatic check_outputs_zero();
      check("rst if_done", {31'd0, bus.if_done}, 32'd0);
      check("rst mem_done", {31'd0, bus.mem_done}, 32'd0);
      check("rst if_data", bus.if_data, 32'd0);
      check("rst mem_rdata", bus.mem_rdata, 32'd0);
      check("rst ram_a", bus.ram_a, 32'd0);
      check("rst ram_dout", {24'd0, bus.ram_dout}, 32'd0);
      check("rst ram_wr", {31'd0, bus.ram_wr}, 32'd0);
   endtask

   // Called at a negedge; the request is sampled at the next posedge (E = cyc+1). A read of n
   // bytes pulses done n+1 edges after E, a write n edges after E; extra covers waits/stalls.
   task automatic run_mem(input logic [31:0] addr, input logic wr, input logic [1:0] len,
                          input logic [31:0] wdata, input logic [31:0] exp_data, input int extra);
      int   n, lat;
      exp_t e;
      logic seen;
      n      = (len == 2'd3) ? 4 : int'(len);
      lat    = wr ? n : n + 1;
      e.data = exp_data;
      e.chk  = !wr;
      e.cyc  = cyc + 1 + extra + lat;
      mem_q.push_back(e);
      bus.mem_req = 1'b1; bus.mem_addr = addr; bus.mem_wr = wr;
      bus.mem_len = len;  bus.mem_wdata = wdata;
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         seen = bus.mem_done;
      end
      if (!seen) check("mem_done timeout", 32'd0, 32'd1);
      bus.mem_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_if(input logic [31:0] addr, input logic [31:0] exp_data, input int extra);
      exp_t e;
      logic seen;
      e.data = exp_data;
      e.chk  = 1'b1;
      e.cyc  = cyc + 1 + extra + 5;
      if_q.push_back(e);
      bus.if_req = 1'b1; bus.if_addr = addr;
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         seen = bus.if_done;
      end
      if (!seen) check("if_done timeout", 32'd0, 32'd1);
      bus.if_req = 1'b0;
      @(negedge clk);
   endtask

   logic [11:0] pl_a [15] = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h000, 12'h001, 12'h002,
                              12'h003, 12'h040, 12'h050, 12'h051, 12'h060, 12'h061, 12'h062,
                              12'h063};
   logic [7:0]  pl_d [15] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h80,
                              8'h34, 8'h12, 8'h78, 8'h56, 8'h34, 8'h12};
   logic [7:0]  sw_bytes [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

   initial begin
      rst = 1'b1; rdy = 1'b1;
      bus.if_req = 1'b0;  bus.if_addr = '0;  bus.if_flush = 1'b0;
      bus.mem_req = 1'b0; bus.mem_addr = '0; bus.mem_wr = 1'b0;
      bus.mem_len = 2'd0; bus.mem_wdata = '0;

      // Preload through the backdoor while the arbiter is held in reset.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         bd_we = 1'b1;
         bd_addr = (i < 15) ? pl_a[i] : 12'hFFF;
         bd_data = (i < 15) ? pl_d[i] : 8'hAA;
      end
      @(negedge clk);
      bd_we = 1'b0;
      check_outputs_zero();
      rst = 1'b0;

      // Instruction fetch, then a word store and its readback.
      run_if(32'h100, 32'h0000_0513, 0);
      wlog.delete();
      run_mem(32'h20, 1'b1, 2'd3, 32'hDEAD_BEEF, 32'h0, 0);
      check("sw write count", wlog.size(), 32'd4);
      for (int i = 0; i < 4 && i < wlog.size(); i++) begin
         check("sw addr", wlog[i].a, 32'h20 + i);
         check("sw byte", {24'd0, wlog[i].d}, {24'd0, sw_bytes[i]});
         check("sw consecutive", wlog[i].cyc, wlog[0].cyc + i);
      end
      run_mem(32'h20, 1'b0, 2'd3, 32'h0, 32'hDEAD_BEEF, 0);

      // Simultaneous requests: MEM byte load first, IF grant after DONE -> IDLE.
      fork
         run_mem(32'h40, 1'b0, 2'd1, 32'h0, 32'h0000_0080, 0);
         run_if(32'h0, 32'h0010_0093, 4);
      join

      // Flush an IF fetch in byte cycle 2; a halfword load takes the freed port.
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      repeat (3) @(negedge clk);
      check("fetch in flight ram_a", bus.ram_a, 32'h102);
      bus.if_flush = 1'b1; bus.if_req = 1'b0;
      fork
         run_mem(32'h50, 1'b0, 2'd2, 32'h0, 32'h0000_1234, 1);
         begin
            @(negedge clk);
            check("flush idle ram_a", bus.ram_a, 32'h0);
            bus.if_flush = 1'b0;
         end
      join

      // Three-cycle stall in byte cycle 2 of a word load.
      fork
         run_mem(32'h60, 1'b0, 2'd3, 32'h0, 32'h1234_5678, 3);
         begin
            repeat (3) @(negedge clk);
            rdy = 1'b0;
            @(negedge clk);
            check("stall ram_a held", bus.ram_a, 32'h62);
            check("stall ram_wr", {31'd0, bus.ram_wr}, 32'd0);
            repeat (2) @(negedge clk);
            rdy = 1'b1;
         end
      join

      // Reset during byte 1 of a store: outputs clear, bytes 0 and 1 stay in RAM.
      bus.mem_req = 1'b1; bus.mem_addr = 32'h30; bus.mem_wr = 1'b1;
      bus.mem_len = 2'd3; bus.mem_wdata = 32'h1122_3344;
      repeat (2) @(negedge clk);
      check("store byte1 ram_wr", {31'd0, bus.ram_wr}, 32'd1);
      rst = 1'b1; bus.mem_req = 1'b0;
      @(negedge clk);
      check_outputs_zero();
      check("partial store byte0", {24'd0, ram[12'h030]}, 32'h44);
      rst = 1'b0;
      @(negedge clk);

      // Word load at the top of the address space wraps to 0.
      fork
         run_mem(32'hFFFF_FFFF, 1'b0, 2'd3, 32'h0, 32'h1000_93AA, 0);
         begin
            repeat (3) @(negedge clk);
            check("wrap ram_a", bus.ram_a, 32'h1);
         end
      join

      repeat (5) @(negedge clk);
      check("if queue drained", if_q.size(), 32'd0);
      check("mem queue drained", mem_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
